// File: rtl/dpb_ctrl.sv
// True dual-port byte-writable RAM with selectable read-during-write behaviour,
// 1- or 2-cycle read latency with per-port valid, and a built-in clear sweep.
module dpb_ctrl #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 10,
  parameter int                    BYTE_WIDTH     = 8,
  parameter int                    READ_LATENCY   = 1,
  parameter int                    RDW_MODE       = 0,
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clear_req,
  output logic                               busy,
  output logic                               collision,
  input  logic                               a_en,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   a_we,
  input  logic [ADDR_WIDTH-1:0]              a_addr,
  input  logic [DATA_WIDTH-1:0]              a_din,
  output logic [DATA_WIDTH-1:0]              a_dout,
  output logic                               a_valid,
  input  logic                               b_en,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   b_we,
  input  logic [ADDR_WIDTH-1:0]              b_addr,
  input  logic [DATA_WIDTH-1:0]              b_din,
  output logic [DATA_WIDTH-1:0]              b_dout,
  output logic                               b_valid
);

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   cnt_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    a_acc, b_acc, a_wr, b_wr, b_wr_ok, coll_d;
  logic [DATA_WIDTH-1:0]   a_rdata_d, b_rdata_d;
  logic [DATA_WIDTH-1:0]   a_d1_q, b_d1_q;
  logic                    a_v1_q, b_v1_q, coll_q;

  assign busy    = (state_q == ST_CLEAR);
  assign a_acc   = a_en & ~busy;
  assign b_acc   = b_en & ~busy;
  assign a_wr    = a_acc & (|a_we);
  assign b_wr    = b_acc & (|b_we);
  // Same-address write-write: port A wins, port B's write is dropped entirely.
  assign coll_d  = a_wr & b_wr & (a_addr == b_addr);
  assign b_wr_ok = b_wr & ~coll_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clear_req) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
          end
        end
        ST_CLEAR: begin
          cnt_q <= cnt_q + ADDR_WIDTH'(1);
          if (cnt_q == '1) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the array has no reset branch; resetting it would prevent block-RAM
  // inference, and the clear engine provides initialisation instead.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[cnt_q] <= CLEAR_VALUE;
    end else begin
      for (int k = 0; k < NB; k++) begin
        if (a_wr && a_we[k])
          mem[a_addr][k*BYTE_WIDTH +: BYTE_WIDTH] <= a_din[k*BYTE_WIDTH +: BYTE_WIDTH];
        if (b_wr_ok && b_we[k])
          mem[b_addr][k*BYTE_WIDTH +: BYTE_WIDTH] <= b_din[k*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Write-first merges each port's own enabled lanes over the pre-edge word,
  // even when that port's write was suppressed by a collision.
  always_comb begin
    a_rdata_d = mem[a_addr];
    b_rdata_d = mem[b_addr];
    if (RDW_MODE == 0) begin
      for (int k = 0; k < NB; k++) begin
        if (a_we[k]) a_rdata_d[k*BYTE_WIDTH +: BYTE_WIDTH] = a_din[k*BYTE_WIDTH +: BYTE_WIDTH];
        if (b_we[k]) b_rdata_d[k*BYTE_WIDTH +: BYTE_WIDTH] = b_din[k*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_d1_q <= '0;
      b_d1_q <= '0;
      a_v1_q <= 1'b0;
      b_v1_q <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      a_v1_q <= a_acc;
      b_v1_q <= b_acc;
      coll_q <= coll_d;
      if (a_acc) a_d1_q <= a_rdata_d;
      if (b_acc) b_d1_q <= b_rdata_d;
    end
  end

  assign collision = coll_q;

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] a_d2_q, b_d2_q;
    logic                  a_v2_q, b_v2_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a_d2_q <= '0;
        b_d2_q <= '0;
        a_v2_q <= 1'b0;
        b_v2_q <= 1'b0;
      end else begin
        a_d2_q <= a_d1_q;
        b_d2_q <= b_d1_q;
        a_v2_q <= a_v1_q;
        b_v2_q <= b_v1_q;
      end
    end

    assign a_dout  = a_d2_q;
    assign b_dout  = b_d2_q;
    assign a_valid = a_v2_q;
    assign b_valid = b_v2_q;
  end else begin : g_lat1
    assign a_dout  = a_d1_q;
    assign b_dout  = b_d1_q;
    assign a_valid = a_v1_q;
    assign b_valid = b_v1_q;
  end

endmodule

// File: tb/tb_dpb_ctrl.sv
// Directed bench for dpb_ctrl: four instances cover write-first/read-first at
// latency 1 and 2, all driven by the same stimulus (instance g: RDW=g%2, lat=1+g/2).
module tb_dpb_ctrl;

  localparam logic [31:0] AR = 32'hA5A5A5A5;

  typedef struct {
    logic        a_en;
    logic [3:0]  a_we;
    logic [3:0]  a_addr;
    logic [31:0] a_din, a_wf, a_rf;
    logic        b_en;
    logic [3:0]  b_we;
    logic [3:0]  b_addr;
    logic [31:0] b_din, b_wf, b_rf;
    logic        coll;
  } vec_t;

  logic        clk, rst, clear_req;
  logic        a_en, b_en;
  logic [3:0]  a_we, b_we, a_addr, b_addr;
  logic [31:0] a_din, b_din;

  logic        busy_w [4];
  logic        coll_w [4];
  logic [31:0] a_dout_w [4];
  logic [31:0] b_dout_w [4];
  logic        a_valid_w [4];
  logic        b_valid_w [4];

  int tests_run = 0;
  int tests_failed = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dpb_ctrl #(
      .DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
      .READ_LATENCY(1 + g / 2), .RDW_MODE(g % 2),
      .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'hA5A5A5A5)
    ) u_dut (
      .clk(clk), .rst(rst), .clear_req(clear_req),
      .busy(busy_w[g]), .collision(coll_w[g]),
      .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
      .a_dout(a_dout_w[g]), .a_valid(a_valid_w[g]),
      .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
      .b_dout(b_dout_w[g]), .b_valid(b_valid_w[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit ae, input int awe, input int aad, input logic [31:0] adin,
                              input logic [31:0] awf, input logic [31:0] arf,
                              input bit be, input int bwe, input int bad, input logic [31:0] bdin,
                              input logic [31:0] bwf, input logic [31:0] brf, input bit c);
    vec_t v;
    v.a_en = ae; v.a_we = 4'(awe); v.a_addr = 4'(aad); v.a_din = adin; v.a_wf = awf; v.a_rf = arf;
    v.b_en = be; v.b_we = 4'(bwe); v.b_addr = 4'(bad); v.b_din = bdin; v.b_wf = bwf; v.b_rf = brf;
    v.coll = c;
    return v;
  endfunction

  task automatic idle_ports();
    a_en = 1'b0; a_we = '0; a_addr = '0; a_din = '0;
    b_en = 1'b0; b_we = '0; b_addr = '0; b_din = '0;
  endtask

  // Checks the outputs of the latency given; the other latency must show no valid.
  task automatic check_stage(input vec_t v, input int idx, input int lat);
    for (int g = 0; g < 4; g++) begin
      if (1 + g / 2 == lat) begin
        check($sformatf("v%0d a_valid[%0d]", idx, g), 32'(a_valid_w[g]), 32'(v.a_en));
        check($sformatf("v%0d b_valid[%0d]", idx, g), 32'(b_valid_w[g]), 32'(v.b_en));
        if (v.a_en)
          check($sformatf("v%0d a_dout[%0d]", idx, g), a_dout_w[g], (g % 2 == 1) ? v.a_rf : v.a_wf);
        if (v.b_en)
          check($sformatf("v%0d b_dout[%0d]", idx, g), b_dout_w[g], (g % 2 == 1) ? v.b_rf : v.b_wf);
      end else begin
        check($sformatf("v%0d a_valid_off[%0d]", idx, g), 32'(a_valid_w[g]), 32'd0);
        check($sformatf("v%0d b_valid_off[%0d]", idx, g), 32'(b_valid_w[g]), 32'd0);
      end
      check($sformatf("v%0d collision[%0d]", idx, g), 32'(coll_w[g]), (lat == 1) ? 32'(v.coll) : 32'd0);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    a_en = v.a_en; a_we = v.a_we; a_addr = v.a_addr; a_din = v.a_din;
    b_en = v.b_en; b_we = v.b_we; b_addr = v.b_addr; b_din = v.b_din;
    @(posedge clk);
    @(negedge clk);
    idle_ports();
    check_stage(v, idx, 1);
    @(posedge clk);
    @(negedge clk);
    check_stage(v, idx, 2);
  endtask

  // Counts negedges on which each instance reports busy, starting at the current one.
  task automatic count_busy(input string name);
    int n [4];
    logic any;
    for (int g = 0; g < 4; g++) n[g] = busy_w[g] ? 1 : 0;
    any = busy_w[0] | busy_w[1] | busy_w[2] | busy_w[3];
    for (int i = 0; i < 40 && any; i++) begin
      @(posedge clk);
      @(negedge clk);
      for (int g = 0; g < 4; g++) if (busy_w[g]) n[g]++;
      any = busy_w[0] | busy_w[1] | busy_w[2] | busy_w[3];
    end
    for (int g = 0; g < 4; g++) check($sformatf("%s busy_cycles[%0d]", name, g), 32'(n[g]), 32'd16);
  endtask

  vec_t vecs [14];
  int   n_busy;

  initial begin
    vecs[0]  = mk(1, 'hF, 3, 32'h11223344, 32'h11223344, AR,            0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 'h5, 3, 32'hAABBCCDD, 32'h11BB33DD, 32'h11223344,  1, 0, 3, 0, 32'h11223344, 32'h11223344, 0);
    vecs[2]  = mk(1, 0, 3, 0, 32'h11BB33DD, 32'h11BB33DD,                1, 'hF, 5, 32'h0, 32'h0, AR, 0);
    vecs[3]  = mk(1, 'hF, 5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,          1, 'hF, 8, 32'h0, 32'h0, AR, 0);
    vecs[4]  = mk(1, 'hF, 7, 32'h1, 32'h1, AR,                           1, 'hF, 7, 32'h2, 32'h2, AR, 1);
    vecs[5]  = mk(1, 0, 7, 0, 32'h1, 32'h1,                              1, 0, 5, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0);
    vecs[6]  = mk(1, 'hF, 8, 32'h9, 32'h9, 32'h0,                        1, 0, 8, 0, 32'h0, 32'h0, 0);
    vecs[7]  = mk(1, 'h1, 10, 32'h000000FF, 32'hA5A5A5FF, AR,            1, 'h8, 10, 32'h11000000, 32'h11A5A5A5, AR, 1);
    vecs[8]  = mk(1, 0, 10, 0, 32'hA5A5A5FF, 32'hA5A5A5FF,               1, 0, 8, 0, 32'h9, 32'h9, 0);
    vecs[9]  = mk(1, 0, 12, 0, AR, AR,                                   1, 'h3, 12, 32'h12345678, 32'hA5A55678, AR, 0);
    vecs[10] = mk(1, 0, 12, 0, 32'hA5A55678, 32'hA5A55678,               1, 'hF, 13, 32'hFFFFFFFF, 32'hFFFFFFFF, AR, 0);
    vecs[11] = mk(1, 'hF, 14, 32'hE, 32'hE, AR,                          1, 'hF, 15, 32'hF, 32'hF, AR, 0);
    vecs[12] = mk(1, 0, 14, 0, 32'hE, 32'hE,                             1, 0, 15, 0, 32'hF, 32'hF, 0);
    vecs[13] = mk(1, 0, 13, 0, 32'hFFFFFFFF, 32'hFFFFFFFF,               0, 0, 0, 0, 0, 0, 0);

    rst = 1'b0;
    clear_req = 1'b0;
    idle_ports();
    #1 rst = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      check($sformatf("reset busy[%0d]", g), 32'(busy_w[g]), 32'd1);
      check($sformatf("reset a_dout[%0d]", g), a_dout_w[g], 32'd0);
      check($sformatf("reset b_dout[%0d]", g), b_dout_w[g], 32'd0);
      check($sformatf("reset valids[%0d]", g), {30'd0, a_valid_w[g], b_valid_w[g]}, 32'd0);
      check($sformatf("reset collision[%0d]", g), 32'(coll_w[g]), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    count_busy("post-reset");

    for (int i = 0; i < 16; i++)
      run_vec(mk(1, 0, i, 0, AR, AR, 1, 0, 15 - i, 0, AR, AR, 0), 100 + i);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // clear_req together with an accepted write: the write drains, then traffic is dropped
    clear_req = 1'b1;
    a_en = 1'b1; a_we = 4'hF; a_addr = 4'd2; a_din = 32'h22;
    @(posedge clk);
    @(negedge clk);
    n_busy = busy_w[0] ? 1 : 0;
    for (int g = 0; g < 4; g++) begin
      check($sformatf("clr busy[%0d]", g), 32'(busy_w[g]), 32'd1);
      check($sformatf("clr drain1 a_valid[%0d]", g), 32'(a_valid_w[g]), (g < 2) ? 32'd1 : 32'd0);
      if (g < 2) check($sformatf("clr drain1 a_dout[%0d]", g), a_dout_w[g], (g % 2 == 1) ? AR : 32'h22);
    end
    a_en = 1'b1; a_we = 4'hF; a_addr = 4'd1; a_din = 32'hDEAD;
    b_en = 1'b1; b_we = 4'h0; b_addr = 4'd4;
    @(posedge clk);
    @(negedge clk);
    if (busy_w[0]) n_busy++;
    for (int g = 0; g < 4; g++) begin
      check($sformatf("clr drain2 a_valid[%0d]", g), 32'(a_valid_w[g]), (g >= 2) ? 32'd1 : 32'd0);
      check($sformatf("clr drain2 b_valid[%0d]", g), 32'(b_valid_w[g]), 32'd0);
      if (g >= 2) check($sformatf("clr drain2 a_dout[%0d]", g), a_dout_w[g], (g % 2 == 1) ? AR : 32'h22);
    end
    for (int i = 0; i < 40 && busy_w[0]; i++) begin
      if (n_busy >= 10) begin
        clear_req = 1'b0;
        idle_ports();
      end
      @(posedge clk);
      @(negedge clk);
      if (busy_w[0]) n_busy++;
      for (int g = 0; g < 4; g++) begin
        check($sformatf("clr drop a_valid[%0d]", g), 32'(a_valid_w[g]), 32'd0);
        check($sformatf("clr drop b_valid[%0d]", g), 32'(b_valid_w[g]), 32'd0);
      end
    end
    check("clr busy_cycles", 32'(n_busy), 32'd16);
    clear_req = 1'b0;
    idle_ports();

    run_vec(mk(1, 0, 1, 0, AR, AR, 1, 0, 2, 0, AR, AR, 0), 200);
    run_vec(mk(1, 0, 13, 0, AR, AR, 1, 0, 8, 0, AR, AR, 0), 201);

    // asynchronous reset in the middle of a sweep
    clear_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear_req = 1'b0;
    repeat (4) @(negedge clk);
    for (int g = 0; g < 4; g++) check($sformatf("pre-rst a_dout[%0d]", g), a_dout_w[g], AR);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      check($sformatf("async rst a_dout[%0d]", g), a_dout_w[g], 32'd0);
      check($sformatf("async rst b_dout[%0d]", g), b_dout_w[g], 32'd0);
      check($sformatf("async rst busy[%0d]", g), 32'(busy_w[g]), 32'd1);
    end
    @(negedge clk);
    rst = 1'b0;
    count_busy("restart");
    run_vec(mk(1, 0, 0, 0, AR, AR, 1, 0, 15, 0, AR, AR, 0), 300);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dpb_ctrl.md
Name: dpb_ctrl

Overview:
- Single-clock, true dual-port block RAM with per-byte write enables, selectable read-during-write mode, and configurable read latency with per-port valid.
- Includes a built-in clear engine that sweeps the array to CLEAR_VALUE after reset or on request.
- Sits between PPU/CPU-side requesters and shared video/work memory, where two masters share one array on one clock.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH
ADDR_WIDTH, 10, address width; depth = 2^ADDR_WIDTH
BYTE_WIDTH, 8, bits per write-enable lane; NB = DATA_WIDTH/BYTE_WIDTH
READ_LATENCY, 1, 1 or 2 cycles from accepted request to dout/valid
RDW_MODE, 0, same-port read-during-write: 0 = write-first, 1 = read-first
CLEAR_ON_RESET, 1, 1 = run a clear sweep after reset; 0 = start idle
CLEAR_VALUE, 0, word written to every address by the clear engine

Ports:
clk  in  1  clock for all logic
rst  in  1  asynchronous, active-high reset
clear_req  in  1  pulse to start a clear sweep
busy  out  1  high while the clear sweep runs
collision  out  1  one-cycle pulse on an A/B write-write address collision
a_en  in  1  port A access request
a_we  in  NB  port A byte write enables; 0 means a read
a_addr  in  ADDR_WIDTH  port A address
a_din  in  DATA_WIDTH  port A write data
a_dout  out  DATA_WIDTH  port A read data
a_valid  out  1  port A a_dout valid strobe
b_en, b_we, b_addr, b_din, b_dout, b_valid: same as port A, for port B

Behaviour:
- Reset, asserted asynchronously:
  - a_dout, b_dout, a_valid, b_valid, collision and all pipeline stages clear to 0.
  - Clear counter goes to 0.
  - State goes to CLEAR if CLEAR_ON_RESET=1, otherwise IDLE; busy follows state.
  - Memory contents are not reset.
- FSM:
  - IDLE: clear_req=1 → CLEAR on the next edge with counter=0.
  - CLEAR: each cycle writes CLEAR_VALUE to mem[counter], then counter+1. After writing address 2^ADDR_WIDTH−1, go to IDLE.
  - busy=1 exactly in CLEAR: 2^ADDR_WIDTH cycles.
  - clear_req while in CLEAR is ignored; it does not restart the sweep.
  - rst mid-sweep restarts per the reset rules.
- Request acceptance:
  - A request is accepted when x_en=1 and busy=0.
  - Requests while busy=1 are dropped: no write, no valid.
  - Requests accepted before CLEAR entry still drain through the pipeline.
- Writes: byte lane k of mem[addr] gets din[k*BYTE_WIDTH +: BYTE_WIDTH] iff we[k]=1. Other lanes are unchanged.
- Read data:
  - Every accepted request (read or write) produces dout and valid=1 exactly READ_LATENCY cycles later.
  - valid is 0 in all other cycles.
  - Pure read: dout = word at addr before the edge.
- Same-port read-during-write:
  - RDW_MODE=0: dout = merged word, i.e. new bytes in enabled lanes, old bytes elsewhere.
  - RDW_MODE=1: dout = old word.
- Cross-port same cycle, one port writes address X and the other reads X: the reader returns the old word.
- Write-write collision:
  - Both accepted, both we≠0, a_addr==b_addr: port A's write is performed and port B's write is fully suppressed.
  - collision=1 for the cycle after the edge, then returns to 0.
  - Each port's dout follows its own RDW rule, computed against the pre-edge word.
- Latency 2: one extra output register stage. Data and valid shift together; there is no stall and no backpressure.
- Address wraparound is not applicable: every address is in range.

Test Plan:
- Reset with CLEAR_ON_RESET=1, ADDR_WIDTH=4, CLEAR_VALUE=32'hA5A5A5A5 → busy=1 for 16 cycles then 0; reads of addresses 0..15 return A5A5A5A5 with valid after READ_LATENCY.
- Port A writes 32'h11223344 to 3 with a_we=4'hF, then writes 32'hAABBCCDD with a_we=4'b0101 → reading 3 returns 32'h11BB33DD.
- RDW: write 32'hDEADBEEF to 5, which holds 32'h0; same-port result → RDW_MODE=0 returns DEADBEEF, RDW_MODE=1 returns 0; valid high only on the latency cycle, checked for both latencies.
- Same cycle A writes 7←32'h1, B writes 7←32'h2 → collision pulses for 1 cycle; a later read of 7 returns 32'h1. Same cycle A writes 8←9 while B reads 8, which holds 0 → b_dout=0.
- clear_req mid-traffic: requests issued while busy → no valid, memory untouched except by the sweep. Second clear_req during the sweep → still exactly 16 busy cycles.
- rst asserted asynchronously between edges mid-sweep → outputs 0 immediately; after release the sweep restarts from address 0.
